// File: rtl/mips_run_pkg.sv
// Shared types, default parameters and helpers for the MIPS run/launch sequencer.
package mips_run_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4,
        TMO    = 3'd5
    } state_t;

    localparam int unsigned DEF_NUM_CORES   = 1;
    localparam int unsigned DEF_HOLD_CYCLES = 2;
    localparam int unsigned DEF_STAGGER     = 0;
    localparam int unsigned DEF_CYCLE_W     = 32;
    localparam int unsigned DEF_TIMEOUT     = 10000;

    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max);
        return (value >= max) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/mips_run_watchdog.sv
// Saturating run-cycle counter with TIMEOUT compare and optional step edge detect.
// Step detect present only when MIPS_RUN_CTRL_STEP_EN is defined.
module mips_run_watchdog
    import mips_run_pkg::*;
#(
    parameter int unsigned CYCLE_W = DEF_CYCLE_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc_en,
`ifdef MIPS_RUN_CTRL_STEP_EN
    input  logic               step,
    output logic               step_rise_c,
`endif
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               expire_c
);

    localparam logic [CYCLE_W-1:0] CNT_MAX   = '1;
    // Only meaningful when TIMEOUT != 0; the compare below is gated on that.
    localparam logic [CYCLE_W-1:0] CNT_LIMIT = CYCLE_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cycle_count <= '0;
        end else if (inc_en) begin
            cycle_count <= CYCLE_W'(sat_inc(SAT_W'(cycle_count), SAT_W'(CNT_MAX)));
        end
    end

    // Expiry coincides with the increment that brings the count to TIMEOUT.
    assign expire_c = (TIMEOUT != 0) && inc_en && (cycle_count == CNT_LIMIT);

`ifdef MIPS_RUN_CTRL_STEP_EN
    logic step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise_c = step & ~step_q;
`endif

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/launch sequencer: holds, staggers and releases MIPS cores, then tracks halt/timeout.
// Optional single-step clock enables via MIPS_RUN_CTRL_STEP_EN.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int unsigned NUM_CORES   = DEF_NUM_CORES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned STAGGER     = DEF_STAGGER,
    parameter int unsigned CYCLE_W     = DEF_CYCLE_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_CORES-1:0] halted,
`ifdef MIPS_RUN_CTRL_STEP_EN
    input  logic                 step,
    output logic [NUM_CORES-1:0] core_ce,
`endif
    output logic [NUM_CORES-1:0] core_initiate,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CYCLE_W-1:0]   cycle_count
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned STAG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NUM_CORES-1:0] ALL_CORES = '1;

    state_t               state_q, state_n;
    logic [HOLD_W-1:0]    hold_q, hold_n;
    logic [STAG_W-1:0]    stag_q, stag_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [NUM_CORES-1:0] mask_q, mask_n;
    logic [NUM_CORES-1:0] init_n;
    logic [NUM_CORES-1:0] halt_now;
    logic                 busy_n, done_n, timeout_n;
    logic                 cnt_clear_c, run_inc_c, expire_c;

`ifdef MIPS_RUN_CTRL_STEP_EN
    logic [NUM_CORES-1:0] ce_n;
    logic                 step_rise_c;
    assign run_inc_c = (state_q == RUN) && !abort && (core_ce != '0);
`else
    assign run_inc_c = (state_q == RUN) && !abort;
`endif

    mips_run_watchdog #(
        .CYCLE_W (CYCLE_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear_c),
        .inc_en      (run_inc_c),
`ifdef MIPS_RUN_CTRL_STEP_EN
        .step        (step),
        .step_rise_c (step_rise_c),
`endif
        .cycle_count (cycle_count),
        .expire_c    (expire_c)
    );

    // Next-state, launch sequencing and flag logic.
    always_comb begin
        state_n     = state_q;
        hold_n      = hold_q;
        stag_n      = stag_q;
        idx_n       = idx_q;
        mask_n      = mask_q;
        init_n      = core_initiate;
        done_n      = done;
        timeout_n   = timeout;
        cnt_clear_c = 1'b0;
        halt_now    = mask_q | (halted & core_initiate);

        if (state_q inside {LAUNCH, RUN, DONE, TMO}) begin
            mask_n = halt_now;
        end

        unique case (state_q)
            IDLE, DONE, TMO: begin
                if (start) begin
                    state_n     = HOLD;
                    hold_n      = HOLD_W'(HOLD_CYCLES - 1);
                    mask_n      = '0;
                    init_n      = '0;
                    done_n      = 1'b0;
                    timeout_n   = 1'b0;
                    cnt_clear_c = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_n = LAUNCH;
                    stag_n  = '0;
                    idx_n   = '0;
                end else begin
                    hold_n = hold_q - HOLD_W'(1);
                end
            end
            LAUNCH: begin
                if (stag_q != '0) begin
                    stag_n = stag_q - STAG_W'(1);
                end else if (STAGGER == 0) begin
                    init_n  = ALL_CORES;
                    state_n = RUN;
                end else begin
                    init_n = core_initiate | (NUM_CORES'(1) << idx_q);
                    if (idx_q == IDX_W'(NUM_CORES - 1)) begin
                        state_n = RUN;
                    end else begin
                        idx_n  = idx_q + IDX_W'(1);
                        stag_n = STAG_W'(STAGGER - 1);
                    end
                end
            end
            RUN: begin
                // A final halt beats a simultaneous watchdog expiry.
                if (&halt_now) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (expire_c) begin
                    state_n   = TMO;
                    timeout_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_n     = IDLE;
            init_n      = '0;
            done_n      = 1'b0;
            timeout_n   = 1'b0;
            cnt_clear_c = 1'b0;
        end

        busy_n = state_n inside {HOLD, LAUNCH, RUN};

`ifdef MIPS_RUN_CTRL_STEP_EN
        ce_n = (state_n == RUN) ? (step_rise_c ? init_n : '0) : init_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            stag_q        <= '0;
            idx_q         <= '0;
            mask_q        <= '0;
            core_initiate <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state_q       <= state_n;
            hold_q        <= hold_n;
            stag_q        <= stag_n;
            idx_q         <= idx_n;
            mask_q        <= mask_n;
            core_initiate <= init_n;
            busy          <= busy_n;
            done          <= done_n;
            timeout       <= timeout_n;
        end
    end

`ifdef MIPS_RUN_CTRL_STEP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            core_ce <= '0;
        end else begin
            core_ce <= ce_n;
        end
    end
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl across three parameter sets, with an
// expected-value queue for per-edge launch patterns.
module tb_mips_run_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // u0: single core, hold 2, watchdog 20
    logic       start0 = 0, abort0 = 0, step0 = 0, busy0, done0, tmo0;
    logic [0:0] halted0 = '0, init0, ce0;
    logic [7:0] cnt0;
    // u1: four cores, hold 1, stagger 2, watchdog 50
    logic        start1 = 0, abort1 = 0, step1 = 0, busy1, done1, tmo1;
    logic [3:0]  halted1 = '0, init1, ce1;
    logic [15:0] cnt1;
    // u2: two cores released together, 4-bit counter, no watchdog
    logic       start2 = 0, abort2 = 0, step2 = 0, busy2, done2, tmo2;
    logic [1:0] halted2 = '0, init2, ce2;
    logic [3:0] cnt2;

    int checks = 0;
    int passed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    mips_run_ctrl #(.NUM_CORES(1), .HOLD_CYCLES(2), .STAGGER(0), .CYCLE_W(8), .TIMEOUT(20)) u0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .halted(halted0),
`ifdef MIPS_RUN_CTRL_STEP_EN
        .step(step0), .core_ce(ce0),
`endif
        .core_initiate(init0), .busy(busy0), .done(done0), .timeout(tmo0), .cycle_count(cnt0));

    mips_run_ctrl #(.NUM_CORES(4), .HOLD_CYCLES(1), .STAGGER(2), .CYCLE_W(16), .TIMEOUT(50)) u1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .halted(halted1),
`ifdef MIPS_RUN_CTRL_STEP_EN
        .step(step1), .core_ce(ce1),
`endif
        .core_initiate(init1), .busy(busy1), .done(done1), .timeout(tmo1), .cycle_count(cnt1));

    mips_run_ctrl #(.NUM_CORES(2), .HOLD_CYCLES(1), .STAGGER(0), .CYCLE_W(4), .TIMEOUT(0)) u2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .halted(halted2),
`ifdef MIPS_RUN_CTRL_STEP_EN
        .step(step2), .core_ce(ce2),
`endif
        .core_initiate(init2), .busy(busy2), .done(done2), .timeout(tmo2), .cycle_count(cnt2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start0 = 1; start1 = 1; start2 = 1;
        tick(); tick();
        checks++; if ({init0, busy0, done0, tmo0, cnt0} !== 12'h0) $display("FAIL reset_u0 got %h want 0", {init0, busy0, done0, tmo0, cnt0}); else passed++;
        checks++; if ({init1, busy1, done1, tmo1, cnt1} !== 23'h0) $display("FAIL reset_u1 got %h want 0", {init1, busy1, done1, tmo1, cnt1}); else passed++;
        checks++; if ({init2, busy2, done2, tmo2, cnt2} !== 9'h0) $display("FAIL reset_u2 got %h want 0", {init2, busy2, done2, tmo2, cnt2}); else passed++;
        reset = 1'b0; start0 = 0; start1 = 0; start2 = 0;
        tick();
        checks++; if (busy1 !== 1'b0) $display("FAIL idle_after_reset busy got %b want 0", busy1); else passed++;
    endtask

    task automatic test_latency();
        start0 = 1; tick(); start0 = 0;
        checks++; if ({busy0, init0} !== 2'b10) $display("FAIL lat_busy got %b want 10", {busy0, init0}); else passed++;
        // core 0 rises HOLD_CYCLES+1 = 3 edges after the sampling edge
        exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h1); exp_q.push_back(16'h1);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++; if (16'(init0) !== exp_v) $display("FAIL lat_init got %h want %h", init0, exp_v); else passed++;
        end
`ifndef MIPS_RUN_CTRL_STEP_EN
        checks++; if (cnt0 !== 8'd1) $display("FAIL lat_cnt got %0d want 1", cnt0); else passed++;
`endif
        halted0 = 1'b1; tick(); halted0 = 1'b0;
        checks++; if ({done0, busy0, tmo0, init0} !== 4'b1001) $display("FAIL lat_done got %b want 1001", {done0, busy0, tmo0, init0}); else passed++;
        tick(); tick();
        checks++; if (done0 !== 1'b1) $display("FAIL done_sticky got %b want 1", done0); else passed++;
`ifndef MIPS_RUN_CTRL_STEP_EN
        checks++; if (cnt0 !== 8'd2) $display("FAIL cnt_frozen got %0d want 2", cnt0); else passed++;
`endif
    endtask

    task automatic test_tie();
        int n;
        start0 = 1; tick(); start0 = 0;
        checks++; if ({init0, done0, busy0, cnt0} !== 11'b0_0_1_00000000) $display("FAIL tie_restart got %b want 00100000000", {init0, done0, busy0, cnt0}); else passed++;
        n = 0;
        while (cnt0 !== 8'd19 && n < 40) begin tick(); n++; end
        checks++; if ({tmo0, cnt0} !== {1'b0, 8'd19}) $display("FAIL tie_wait tmo/cnt got %b/%0d want 0/19", tmo0, cnt0); else passed++;
        halted0 = 1'b1; tick(); halted0 = 1'b0;
        checks++; if ({done0, tmo0} !== 2'b10) $display("FAIL tie_done done/tmo got %b want 10", {done0, tmo0}); else passed++;
        checks++; if (cnt0 !== 8'd20) $display("FAIL tie_cnt got %0d want 20", cnt0); else passed++;
    endtask

    task automatic test_stagger();
        start1 = 1; tick(); start1 = 0;
        exp_q.push_back(16'h0); exp_q.push_back(16'h1); exp_q.push_back(16'h1); exp_q.push_back(16'h3);
        exp_q.push_back(16'h3); exp_q.push_back(16'h7); exp_q.push_back(16'h7); exp_q.push_back(16'hf);
        for (int k = 1; k <= 8; k++) begin
            tick();
            // halts from unreleased cores 1..3 must not stick
            halted1 = (k == 2) ? 4'hf : 4'h0;
            exp_v = exp_q.pop_front();
            checks++; if (16'(init1) !== exp_v) $display("FAIL stagger_off%0d got %h want %h", k, init1, exp_v); else passed++;
        end
        halted1 = 4'h0;
        checks++; if ({busy1, done1} !== 2'b10) $display("FAIL stagger_run busy/done got %b want 10", {busy1, done1}); else passed++;
    endtask

    task automatic test_watchdog();
        int n;
        n = 0;
        while (tmo1 !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 50) $display("FAIL wd_latency got %0d want 50", n); else passed++;
        checks++; if ({tmo1, done1, busy1, init1} !== 7'b100_1111) $display("FAIL wd_flags got %b want 1001111", {tmo1, done1, busy1, init1}); else passed++;
        checks++; if (cnt1 !== 16'd50) $display("FAIL wd_cnt got %0d want 50", cnt1); else passed++;
        start1 = 1; tick(); start1 = 0;
        checks++; if ({init1, tmo1, busy1, cnt1} !== {4'h0, 1'b0, 1'b1, 16'd0}) $display("FAIL wd_restart got %h want %h", {init1, tmo1, busy1, cnt1}, {4'h0, 1'b0, 1'b1, 16'd0}); else passed++;
    endtask

`ifdef MIPS_RUN_CTRL_STEP_EN
    task automatic test_step();
        int pulses;
        checks++; if (ce1 !== 4'h0) $display("FAIL step_idle_ce got %h want 0", ce1); else passed++;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'hf); exp_q.push_back(16'h0);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step1 = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            exp_v = exp_q.pop_front();
            if (ce1 != 4'h0) pulses++;
            checks++; if (16'(ce1) !== exp_v) $display("FAIL step_ce%0d got %h want %h", i, ce1, exp_v); else passed++;
        end
        step1 = 1'b0;
        tick(); tick(); tick();
        checks++; if (pulses !== 5) $display("FAIL step_pulses got %0d want 5", pulses); else passed++;
        checks++; if (cnt1 !== 16'd5) $display("FAIL step_cnt got %0d want 5", cnt1); else passed++;
        abort1 = 1; tick(); abort1 = 0;
        checks++; if ({busy1, cnt1} !== {1'b0, 16'd5}) $display("FAIL step_abort_keep got %h want 5", {busy1, cnt1}); else passed++;
        start1 = 1; tick(); start1 = 0;
    endtask
`endif

    task automatic test_abort();
        tick(); tick(); tick(); tick();
        checks++; if (init1 !== 4'h3) $display("FAIL abort_pre got %h want 3", init1); else passed++;
        abort1 = 1; start1 = 1; tick(); abort1 = 0; start1 = 0;
        checks++; if ({init1, busy1, done1, tmo1} !== 7'h0) $display("FAIL abort_idle got %b want 0", {init1, busy1, done1, tmo1}); else passed++;
        tick(); tick();
        checks++; if ({busy1, init1} !== 5'h0) $display("FAIL abort_start_ignored got %b want 0", {busy1, init1}); else passed++;
    endtask

    task automatic test_saturate();
        start2 = 1; tick(); start2 = 0;
        exp_q.push_back(16'h0); exp_q.push_back(16'h3);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++; if (16'(init2) !== exp_v) $display("FAIL sat_init got %h want %h", init2, exp_v); else passed++;
        end
`ifndef MIPS_RUN_CTRL_STEP_EN
        for (int i = 0; i < 25; i++) tick();
        checks++; if ({cnt2, busy2, tmo2} !== {4'hf, 1'b1, 1'b0}) $display("FAIL sat_cnt got %b want 111110", {cnt2, busy2, tmo2}); else passed++;
`endif
        halted2 = 2'b01; tick(); halted2 = 2'b00; tick();
        checks++; if (done2 !== 1'b0) $display("FAIL sat_partial_done got %b want 0", done2); else passed++;
        halted2 = 2'b10; tick(); halted2 = 2'b00;
        checks++; if ({done2, busy2} !== 2'b10) $display("FAIL sat_done got %b want 10", {done2, busy2}); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
`ifndef MIPS_RUN_CTRL_STEP_EN
        test_tie();
`endif
        test_stagger();
`ifdef MIPS_RUN_CTRL_STEP_EN
        test_step();
`else
        test_watchdog();
`endif
        test_abort();
        test_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
